// File: rtl/sp_ram_ctrl.sv
// Request-side controller for a single-port RAM with a registered read and an output enable.
// Arbitrates write and read requests round-robin and returns read data on a response channel.
module sp_ram_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StWrite  = 2'd1;
    localparam logic [1:0] StRdAddr = 2'd2;
    localparam logic [1:0] StRdData = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  wr_prio_q, wr_prio_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic idle, wr_elig, rd_elig, grant_wr, grant_rd;

    // Gate with rst_n so the ready outputs are low while reset is held.
    assign idle     = (state_q == StIdle) && rst_n;
    assign wr_elig  = wr_valid;
    assign rd_elig  = rd_valid && !rsp_valid_q;
    assign grant_wr = idle && wr_elig && (wr_prio_q || !rd_elig);
    assign grant_rd = idle && rd_elig && (!wr_prio_q || !wr_elig);

    assign wr_ready  = grant_wr;
    assign rd_ready  = grant_rd;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign ram_addr  = addr_q;

    // Only the WRITE state drives the bus; the RAM drives it only in RD_DATA.
    assign ram_data = (state_q == StWrite) ? wdata_q : {DATA_WIDTH{1'bz}};

    always_comb begin
        state_d     = state_q;
        wr_prio_d   = wr_prio_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        case (state_q)
            StIdle: begin
                if (grant_wr) begin
                    state_d   = StWrite;
                    addr_d    = wr_addr;
                    wdata_d   = wr_data;
                    wr_prio_d = 1'b0;
                end else if (grant_rd) begin
                    state_d   = StRdAddr;
                    addr_d    = rd_addr;
                    wr_prio_d = 1'b1;
                end
            end
            StWrite:  state_d = StIdle;
            StRdAddr: state_d = StRdData;
            StRdData: begin
                state_d     = StIdle;
                rsp_valid_d = 1'b1;
                rsp_data_d  = ram_data;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ram_cs = 1'b0;
        ram_we = 1'b0;
        ram_oe = 1'b0;
        case (state_q)
            StWrite: begin
                ram_cs = 1'b1;
                ram_we = 1'b1;
            end
            StRdAddr: ram_cs = 1'b1;
            StRdData: begin
                ram_cs = 1'b1;
                ram_oe = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_prio_q   <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_prio_q   <= wr_prio_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Bench for sp_ram_ctrl: a registered-read RAM model on the bus plus a cycle-schedule reference
// model that predicts handshakes, RAM pins and responses from the request history.
module tb_sp_ram_ctrl;

    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [AW-1:0] wr_addr, rd_addr, ram_addr;
    logic [DW-1:0] wr_data, rsp_data;
    logic          ram_cs, ram_we, ram_oe;
    wire  [DW-1:0] ram_bus;

    sp_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_addr   (rd_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_addr  (ram_addr),
        .ram_data  (ram_bus),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_oe    (ram_oe)
    );

    always #5 clk = ~clk;

    // RAM model: commits on cs&we, latches read data on cs&!we, drives bus when oe.
    logic [DW-1:0] ram_mem [16];
    logic [DW-1:0] ram_tmp;
    assign ram_bus = (ram_cs && ram_oe && !ram_we) ? ram_tmp : {DW{1'bz}};
    always @(posedge clk) begin
        if (ram_cs && ram_we) ram_mem[ram_addr] <= ram_bus;
        else if (ram_cs) ram_tmp <= ram_mem[ram_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: cycle schedule of the RAM port plus a copy of memory contents.
    int            cyc, free_at, wr_cyc, rd_cyc, rsp_set_at;
    bit            last_wr, m_rsp_valid;
    logic [DW-1:0] m_rsp_data, pend_data, wdata_exp;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] model_mem [16];
    byte           grants[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc         = 0;
        free_at     = 0;
        wr_cyc      = -10;
        rd_cyc      = -10;
        rsp_set_at  = -10;
        last_wr     = 1'b0;
        m_rsp_valid = 1'b0;
        m_rsp_data  = '0;
        pend_data   = '0;
        wdata_exp   = '0;
        exp_addr    = '0;
    endtask

    // One cycle: drive at negedge, check #1 later, advance to next negedge.
    task automatic step(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input bit rv, input logic [AW-1:0] ra, input bit rr);
        bit idle, we_e, re_e, g_w, g_r, is_w, is_ra, is_rd;
        wr_valid  = wv;
        wr_addr   = wa;
        wr_data   = wd;
        rd_valid  = rv;
        rd_addr   = ra;
        rsp_ready = rr;
        #1;
        if (cyc == rsp_set_at) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = pend_data;
        end
        idle  = (cyc >= free_at);
        we_e  = wv;
        re_e  = rv && !m_rsp_valid;
        g_w   = idle && we_e && (!re_e || !last_wr);
        g_r   = idle && re_e && (!we_e || last_wr);
        is_w  = (cyc == wr_cyc);
        is_ra = (cyc == rd_cyc);
        is_rd = (cyc == rd_cyc + 1);
        chk("wr_ready", 64'(wr_ready), 64'(g_w));
        chk("rd_ready", 64'(rd_ready), 64'(g_r));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        chk("rsp_data", 64'(rsp_data), 64'(m_rsp_data));
        chk("ram_cs", 64'(ram_cs), 64'(is_w || is_ra || is_rd));
        chk("ram_we", 64'(ram_we), 64'(is_w));
        chk("ram_oe", 64'(ram_oe), 64'(is_rd));
        chk("ram_addr", 64'(ram_addr), 64'(exp_addr));
        if (is_w) chk("bus_write", 64'(ram_bus), 64'(wdata_exp));
        if (is_rd) chk("bus_read", 64'(ram_bus), 64'(pend_data));
        if (g_w) begin
            model_mem[wa] = wd;
            exp_addr      = wa;
            wdata_exp     = wd;
            wr_cyc        = cyc + 1;
            free_at       = cyc + 2;
            last_wr       = 1'b1;
            grants.push_back("W");
        end
        if (g_r) begin
            pend_data  = model_mem[ra];
            exp_addr   = ra;
            rd_cyc     = cyc + 1;
            free_at    = cyc + 3;
            rsp_set_at = cyc + 3;
            last_wr    = 1'b0;
            grants.push_back("R");
        end
        if (m_rsp_valid && rr) m_rsp_valid = 1'b0;
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d);
        step(1'b1, a, d, 1'b0, '0, 1'b1);
        idle_steps(1);
    endtask

    task automatic rd_op(input logic [AW-1:0] a);
        step(1'b0, '0, '0, 1'b1, a, 1'b1);
        idle_steps(3);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cs"}, 64'(ram_cs), 64'(0));
        chk({tag, "_we"}, 64'(ram_we), 64'(0));
        chk({tag, "_oe"}, 64'(ram_oe), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
        chk({tag, "_ram_addr"}, 64'(ram_addr), 64'(0));
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'(0));
        chk({tag, "_rd_ready"}, 64'(rd_ready), 64'(0));
    endtask

    initial begin
        logic [AW-1:0] ra, wa;
        logic [DW-1:0] wd;
        bit            wv, rv, rr;

        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        rd_valid  = 1'b0;
        rsp_ready = 1'b0;
        wr_addr   = '0;
        rd_addr   = '0;
        wr_data   = '0;
        repeat (2) @(negedge clk);
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Basic write then read of the same address.
        wr_op(4'd3, 32'hDEADBEEF);
        rd_op(4'd3);
        chk("rd3_value", 64'(rsp_data), 64'(32'hDEADBEEF));

        // Extreme addresses must not alias.
        wr_op(4'd15, 32'h1);
        wr_op(4'd0, 32'h2);
        rd_op(4'd15);
        chk("rd15_value", 64'(rsp_data), 64'(32'h1));
        rd_op(4'd0);
        chk("rd0_value", 64'(rsp_data), 64'(32'h2));

        // Both channels always requesting: strict alternation starting with write.
        do_reset();
        grants.delete();
        for (int i = 0; i < 12; i++) step(1'b1, 4'd5, 32'h100 + i, 1'b1, 4'd3, 1'b1);
        chk("rr_count", 64'(grants.size()), 64'(5));
        for (int i = 0; i < grants.size(); i++) begin
            chk("rr_order", 64'(grants[i]), (i % 2 == 0) ? 64'("W") : 64'("R"));
        end
        idle_steps(4);

        // Unconsumed response stalls reads but lets writes through.
        grants.delete();
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd0, 32'hA0, 1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd1, 32'hA1, 1'b1, 4'd15, 1'b0);
        step(1'b1, 4'd1, 32'hA1, 1'b1, 4'd15, 1'b0);
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b0);
        chk("stall_data", 64'(rsp_data), 64'(32'h1));
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b1);
        step(1'b0, '0, '0, 1'b1, 4'd15, 1'b1);
        chk("stall_grants", 64'(grants.size()), 64'(4));
        chk("stall_g1", 64'(grants[1]), 64'("W"));
        chk("stall_g2", 64'(grants[2]), 64'("W"));
        chk("stall_g3", 64'(grants[3]), 64'("R"));
        idle_steps(4);
        rd_op(4'd1);
        chk("stall_wr1", 64'(rsp_data), 64'(32'hA1));

        // Fill memory, then randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) wr_op(AW'(i), $urandom);
        for (int i = 0; i < 400; i++) begin
            wv = ($urandom_range(0, 2) != 0);
            rv = ($urandom_range(0, 2) != 0);
            rr = ($urandom_range(0, 3) != 0);
            wa = AW'($urandom);
            ra = AW'($urandom);
            wd = $urandom;
            step(wv, wa, wd, rv, ra, rr);
        end
        idle_steps(5);

        // Reset asserted while in RD_ADDR drops the read.
        step(1'b0, '0, '0, 1'b1, 4'd7, 1'b1);
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle_steps(4);
        wr_op(4'd7, 32'h5A5A_0707);
        rd_op(4'd7);
        chk("post_reset_rd", 64'(rsp_data), 64'(32'h5A5A_0707));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
